rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Shares that port between two sources:
  - the in-order pipeline writeback (WB), which has priority;
  - a long-latency unit (LL: mul/div/load miss), which uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a per-register scoreboard of outstanding LL destinations, so decode can detect RAW/WAW hazards on its three read addresses and its issuing destination.
- A starvation guard briefly holds WB so buffered LL results always drain.

Parameters:
- FIFO_DEPTH, 4, number of buffered LL results (power of 2, at least 2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before WB is held.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wb_we  in  1  pipeline writeback request
- wb_wa  in  5  WB destination register
- wb_wd  in  32  WB data
- wb_hold  out  1  WB not accepted this cycle; pipeline must re-present the same write next cycle
- ll_valid  in  1  LL result valid
- ll_ready  out  1  arbiter can accept an LL result
- ll_wa  in  5  LL destination register
- ll_wd  in  32  LL data
- sb_set  in  1  decode issues an LL op
- sb_rd  in  5  destination of the issued LL op
- ra0, ra1, ra2  in  5 each  decode source addresses
- hz0, hz1, hz2  out  1 each  source register has a pending LL write
- hz_rd  out  1  sb_rd already pending (WAW)
- rf_we  out  1  register file write enable
- rf_wa  out  5  register file write address
- rf_wd  out  32  register file write data
- ll_empty  out  1  FIFO empty

Behaviour:
- Reset values:
  - rf_we=0, rf_wa=0, rf_wd=0.
  - FIFO empty (ll_empty=1, ll_ready=1).
  - All pending bits 0; starve_cnt=0; wb_hold=0; hz* = 0.
- Reset mid-operation discards FIFO contents and pending bits immediately.
- LL handshake:
  - ll_ready = !full. It is combinational from registered FIFO state only.
  - A transfer occurs on a clock edge with ll_valid && ll_ready.
  - ll_wa=0 transfers are accepted and dropped: no FIFO entry, no write.
- FIFO: circular, with wrap-around pointers and a count. Enqueue and dequeue in the same cycle while full is legal and keeps the count; ll_ready stays 0 in that cycle.
- Hold: wb_hold = (starve_cnt == STARVE_LIMIT) && !ll_empty. It must not depend on wb_we (no combinational loop).
- Arbitration, evaluated each cycle:
  - If wb_hold: grant the FIFO head.
  - Else if wb_we: grant WB.
  - Else if FIFO non-empty: grant the FIFO head.
  - Else: no write.
- A WB write with wb_wa=0 is granted but produces rf_we=0.
- Output latency: the grant is registered into rf_we/rf_wa/rf_wd, 1 cycle after the request. The register file then commits on the following edge.
- starve_cnt:
  - Increments while the FIFO is non-empty and WB wins.
  - Clears when the head dequeues or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Scoreboard (pending[31:1]; pending[0] is hardwired 0):
  - Set: sb_set with sb_rd != 0.
  - Clear: when a registered rf_we originating from LL commits to rf_wa (a src_ll flag travels with the output register).
  - Set and clear of the same register in the same cycle: set wins.
- Hazard outputs:
  - hzN = pending[raN], combinational; 0 when raN=0.
  - hz_rd = pending[sb_rd].
- WB writing a pending register does not clear the pending bit. Decode must not issue on hz_rd.

Optional Feature:
- Macro: RF_WB_LL_BYPASS_EN.
- Defined: when the FIFO is empty, wb_we=0 and ll_valid with ll_wa != 0, the LL result is granted directly to the output register in the same cycle without enqueuing. ll_ready is still !full. Latency is 1 cycle.
- Undefined: every LL result enqueues, giving a minimum latency of 2 cycles from ll_valid to rf_we.

Decomposition:
- Package rf_arb_pkg holds:
  - REG_AW=5, XLEN=32, the reg-address and data typedefs;
  - the grant-source enum {GNT_NONE, GNT_WB, GNT_LL}.
- Sub-module rf_ll_fifo: parameterised FIFO_DEPTH, exposing push/pop/full/empty/head.
- Scoreboard and arbitration stay in the top module.

Test Plan:
- WB only: wb_we=1, wb_wa=5, wb_wd=0xDEADBEEF at cycle N -> rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF at N+1; wb_hold=0.
- Scoreboard RAW:
  - Stimulus: sb_set rd=7; ra1=7; later ll result wa=7, wd=0x11 with WB idle.
  - Response: hz1=1 until the edge the LL write commits, then hz1=0; rf_wd=0x11.
  - Also: sb_set rd=0 leaves all hz=0.
- Starvation:
  - Stimulus: wb_we=1 every cycle; one LL result wa=3.
  - Response: after 8 cycles of WB wins, wb_hold=1 for exactly 1 cycle; rf_wa=3 the next cycle; the held WB write appears the cycle after.
- Full FIFO: push 4 LL results while wb_we=1 continuously -> ll_ready=0 after the 4th transfer; a 5th ll_valid is not accepted until a dequeue; no data lost or reordered.
- Reset mid-operation: assert rst with 3 entries queued and pending bits {3, 9} set -> ll_empty=1, rf_we=0, hz*=0 immediately and after release; no stale writes.
- Bypass: single ll_valid wa=12 into an idle arbiter -> rf_we at +1 cycle with RF_WB_LL_BYPASS_EN defined, at +2 cycles without.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Optional LL bypass path is enabled with RF_WB_LL_BYPASS_EN.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xdata_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_LL
  } gnt_src_e;

  typedef struct packed {
    reg_addr_t wa;
    xdata_t    wd;
  } ll_entry_t;

endpackage

// File: rtl/rf_ll_fifo.sv
// Circular buffer for long-latency results waiting for the write port.
// Independent of RF_WB_LL_BYPASS_EN; bypass is decided in the top.
module rf_ll_fifo
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  ll_entry_t entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output ll_entry_t head_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  ll_entry_t     mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push while full is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB priority, buffered LL results, LL scoreboard.
// Define RF_WB_LL_BYPASS_EN to let an LL result skip the empty FIFO.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              wb_hold,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_wa,
  input  logic [XLEN-1:0]   ll_wd,
  input  logic              sb_set,
  input  logic [REG_AW-1:0] sb_rd,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic              hz0,
  output logic              hz1,
  output logic              hz2,
  output logic              hz_rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              ll_empty
);

  localparam int NREG = 1 << REG_AW;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  gnt_src_e        gnt;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop, bypass;
  ll_entry_t       head, ll_in;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d, src_ll_q, src_ll_d;
  reg_addr_t       rf_wa_q, rf_wa_d;
  xdata_t          rf_wd_q, rf_wd_d;
  logic [NREG-1:0] pend_q, pend_d;

  // Handshake: an LL result transfers on a clock edge where ll_valid && ll_ready;
  // ll_ready depends only on registered FIFO occupancy, never on ll_valid.
  assign ll_in    = {ll_wa, ll_wd};
  assign ll_ready = !fifo_full;
  assign ll_empty = fifo_empty;
  assign wb_hold  = (starve_q == SW'(STARVE_LIMIT)) && !fifo_empty;

  rf_ll_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .entry_i (ll_in),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  always_comb begin
    gnt      = GNT_NONE;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (wb_hold) begin
      gnt      = GNT_LL;
      fifo_pop = 1'b1;
    end else if (wb_we) begin
      gnt = GNT_WB;
    end else if (!fifo_empty) begin
      gnt      = GNT_LL;
      fifo_pop = 1'b1;
    end
`ifdef RF_WB_LL_BYPASS_EN
    else if (ll_valid && ll_wa != '0) begin
      gnt    = GNT_LL;
      bypass = 1'b1;
    end
`endif
  end

  // Writes to x0 are accepted on the handshake but never buffered.
  assign fifo_push = ll_valid && ll_ready && (ll_wa != '0) && !bypass;

  always_comb begin
    rf_we_d  = 1'b0;
    src_ll_d = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    case (gnt)
      GNT_WB: begin
        rf_we_d = (wb_wa != '0);
        rf_wa_d = wb_wa;
        rf_wd_d = wb_wd;
      end
      GNT_LL: begin
        rf_we_d  = 1'b1;
        src_ll_d = 1'b1;
        rf_wa_d  = bypass ? ll_wa : head.wa;
        rf_wd_d  = bypass ? ll_wd : head.wd;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop)
      starve_d = '0;
    else if (gnt == GNT_WB && starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
  end

  // Clear first so a same-cycle re-issue of the register keeps it pending.
  always_comb begin
    pend_d = pend_q;
    if (rf_we_q && src_ll_q) pend_d[rf_wa_q] = 1'b0;
    if (sb_set && sb_rd != '0) pend_d[sb_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      rf_we_q  <= 1'b0;
      src_ll_q <= 1'b0;
      rf_wa_q  <= '0;
      rf_wd_q  <= '0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q  <= rf_we_d;
      src_ll_q <= src_ll_d;
      rf_wa_q  <= rf_wa_d;
      rf_wd_q  <= rf_wd_d;
      pend_q   <= pend_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign hz0   = pend_q[ra0];
  assign hz1   = pend_q[ra1];
  assign hz2   = pend_q[ra2];
  assign hz_rd = pend_q[sb_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, corner sequences and a random run
// against a queue-based reference model; honours RF_WB_LL_BYPASS_EN.
module tb_rf_wb_arbiter;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef RF_WB_LL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk, rst;
  logic        wb_we, wb_hold, ll_valid, ll_ready, sb_set;
  logic [4:0]  wb_wa, ll_wa, sb_rd, ra0, ra1, ra2, rf_wa;
  logic [31:0] wb_wd, ll_wd, rf_wd;
  logic        hz0, hz1, hz2, hz_rd, rf_we, ll_empty;

  rf_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_hold(wb_hold),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
    .sb_set(sb_set), .sb_rd(sb_rd), .ra0(ra0), .ra1(ra1), .ra2(ra2),
    .hz0(hz0), .hz1(hz1), .hz2(hz2), .hz_rd(hz_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .ll_empty(ll_empty)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending LL results as a queue, pending registers as a bit set
  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ll_t;

  ll_t         m_q[$];
  bit [31:0]   m_pend;
  int          m_starve;
  bit          m_we, m_src, m_acc, m_hold;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        d_hold, d_ready;
  logic [36:0] exp_q[$];

  task automatic model_reset();
    m_q.delete();
    m_pend   = '0;
    m_starve = 0;
    m_we     = 1'b0;
    m_src    = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    m_acc    = 1'b0;
    m_hold   = 1'b0;
  endtask

  task automatic set_idle();
    wb_we = 0; wb_wa = 0; wb_wd = 0;
    ll_valid = 0; ll_wa = 0; ll_wd = 0;
    sb_set = 0; sb_rd = 0; ra0 = 0; ra1 = 0; ra2 = 0;
  endtask

  // Called ~1 time unit after a rising edge with inputs already driven.
  task automatic step();
    bit  empty, full, hold, pop, byp;
    int  gnt;
    ll_t head, e;
    #1;
    empty = (m_q.size() == 0);
    full  = (m_q.size() == FIFO_DEPTH);
    hold  = (m_starve == STARVE_LIMIT) && !empty;
    d_hold  = wb_hold;
    d_ready = ll_ready;
    check1("ll_ready", ll_ready, !full);
    check1("ll_empty", ll_empty, empty);
    check1("wb_hold", wb_hold, hold);
    check1("hz0", hz0, m_pend[ra0]);
    check1("hz1", hz1, m_pend[ra1]);
    check1("hz2", hz2, m_pend[ra2]);
    check1("hz_rd", hz_rd, m_pend[sb_rd]);
    m_hold = hold;
    m_acc  = ll_valid && !full;
    head   = empty ? '0 : m_q[0];
    pop = 0; byp = 0; gnt = 0;
    if (hold) begin gnt = 2; pop = 1; end
    else if (wb_we) gnt = 1;
    else if (!empty) begin gnt = 2; pop = 1; end
    else if (BYPASS && ll_valid && ll_wa != 0) begin gnt = 2; byp = 1; end
    if (m_we && m_src) m_pend[m_wa] = 1'b0;
    if (sb_set && sb_rd != 0) m_pend[sb_rd] = 1'b1;
    if (empty || pop) m_starve = 0;
    else if (gnt == 1 && m_starve < STARVE_LIMIT) m_starve++;
    case (gnt)
      1: begin m_we = (wb_wa != 0); m_src = 0; m_wa = wb_wa; m_wd = wb_wd; end
      2: begin
        m_we = 1; m_src = 1;
        m_wa = byp ? ll_wa : head.wa;
        m_wd = byp ? ll_wd : head.wd;
      end
      default: begin m_we = 0; m_src = 0; end
    endcase
    if (pop) void'(m_q.pop_front());
    if (m_acc && ll_wa != 0 && !byp) begin
      e.wa = ll_wa; e.wd = ll_wd;
      m_q.push_back(e);
    end
    @(posedge clk); #1;
    check1("rf_we", rf_we, m_we);
    if (m_we) begin
      check32("rf_wa", {27'd0, rf_wa}, {27'd0, m_wa});
      check32("rf_wd", rf_wd, m_wd);
    end
  endtask

  typedef struct {
    logic        wb_we;  logic [4:0] wb_wa;  logic [31:0] wb_wd;
    logic        ll_valid; logic [4:0] ll_wa; logic [31:0] ll_wd;
    logic        sb_set; logic [4:0] sb_rd;  logic [4:0] ra1;
    logic        e_hz1;  logic e_ready;
    logic        e_we;   logic [4:0] e_wa;   logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int hold_cnt, first_hold, n, acc5_cyc, first_ll_cyc, k_done;
    logic [31:0] wd_cur, held_wd;
    logic [36:0] got;

    // WB write, RAW scoreboard set/clear, sb_rd=0, WB to x0
    tbl[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 1, 1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd7, 5'd7, 0, 1, 0, 5'd0, 32'h0};
    tbl[2] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 1, 1, 0, 5'd0, 32'h0};
    tbl[3] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  1, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0};
    tbl[4] = '{1, 5'd2, 32'h22,       1, 5'd7, 32'h11, 0, 5'd0, 5'd7, 1, 1, 1, 5'd2, 32'h22};
    tbl[5] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 1, 1, 1, 5'd7, 32'h11};
    tbl[6] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 1, 1, 0, 5'd0, 32'h0};
    tbl[7] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 0, 1, 0, 5'd0, 32'h0};
    tbl[8] = '{1, 5'd0, 32'h55,       0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 0, 1, 0, 5'd0, 32'h0};

    rst = 1'b1;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check1("rst_rf_we", rf_we, 1'b0);
    check32("rst_rf_wa", {27'd0, rf_wa}, 32'd0);
    check32("rst_rf_wd", rf_wd, 32'd0);
    check1("rst_ll_empty", ll_empty, 1'b1);
    check1("rst_ll_ready", ll_ready, 1'b1);
    check1("rst_wb_hold", wb_hold, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // vector table
    for (int i = 0; i < 9; i++) begin
      wb_we = tbl[i].wb_we; wb_wa = tbl[i].wb_wa; wb_wd = tbl[i].wb_wd;
      ll_valid = tbl[i].ll_valid; ll_wa = tbl[i].ll_wa; ll_wd = tbl[i].ll_wd;
      sb_set = tbl[i].sb_set; sb_rd = tbl[i].sb_rd; ra1 = tbl[i].ra1;
      #1;
      check1($sformatf("tbl%0d_hz1", i), hz1, tbl[i].e_hz1);
      check1($sformatf("tbl%0d_ready", i), ll_ready, tbl[i].e_ready);
      step();
      check1($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].e_we);
      if (tbl[i].e_we) begin
        check32($sformatf("tbl%0d_rf_wa", i), {27'd0, rf_wa}, {27'd0, tbl[i].e_wa});
        check32($sformatf("tbl%0d_rf_wd", i), rf_wd, tbl[i].e_wd);
      end
    end
    set_idle();
    step();

    // starvation: continuous WB with one buffered LL result
    wb_we = 1; wb_wa = 5'd4; wb_wd = 32'h1000;
    ll_valid = 1; ll_wa = 5'd3; ll_wd = 32'h33;
    step();
    ll_valid = 0; ll_wa = 0; ll_wd = 0;
    hold_cnt = 0; first_hold = 0; wd_cur = 32'h1000; held_wd = 0;
    for (int k = 1; k <= 12; k++) begin
      if (!m_hold) wd_cur = 32'h1000 + k;
      wb_wd = wd_cur;
      step();
      if (k == first_hold + 1 && first_hold != 0) begin
        check32("starve_held_wa", {27'd0, rf_wa}, 32'd4);
        check32("starve_held_wd", rf_wd, held_wd);
      end
      if (d_hold) begin
        hold_cnt++;
        if (first_hold == 0) begin
          first_hold = k;
          held_wd = wd_cur;
          check32("starve_hold_cycle", k, 9);
          check32("starve_ll_wa", {27'd0, rf_wa}, 32'd3);
        end
      end
    end
    check32("starve_hold_count", hold_cnt, 1);
    set_idle();
    step();

    // full FIFO under continuous WB: order kept, 5th waits for a dequeue
    n = 0; acc5_cyc = -1; first_ll_cyc = -1; k_done = 0;
    exp_q.delete();
    for (int k = 0; k < 150 && k_done == 0; k++) begin
      wb_we = 1; wb_wa = 5'd1; wb_wd = $urandom;
      ll_valid = (n < 5); ll_wa = 5'(8 + n); ll_wd = 32'hA0 + n;
      step();
      if (ll_valid && d_ready) begin
        exp_q.push_back({ll_wa, ll_wd});
        n++;
        if (n == 4) check1("full_ready_after_4", ll_ready, 1'b0);
        if (n == 5) acc5_cyc = k;
      end
      if (rf_we && rf_wa != 5'd1) begin
        if (first_ll_cyc < 0) first_ll_cyc = k;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL full_unexpected: actual wa=%0d wd=%0h required none", rf_wa, rf_wd);
        end else begin
          got = exp_q.pop_front();
          check32("full_order_wa", {27'd0, rf_wa}, {27'd0, got[36:32]});
          check32("full_order_wd", rf_wd, got[31:0]);
        end
      end
      if (n == 5 && exp_q.size() == 0) k_done = 1;
    end
    check1("full_drained", k_done[0], 1'b1);
    check1("full_5th_after_deq", (acc5_cyc > first_ll_cyc) && (first_ll_cyc >= 0), 1'b1);
    set_idle();
    step();

    // reset mid-operation with 3 queued entries and pending {3,9}
    sb_set = 1; sb_rd = 5'd3; step();
    sb_rd = 5'd9; step();
    sb_set = 0; sb_rd = 0;
    for (int k = 0; k < 3; k++) begin
      wb_we = 1; wb_wa = 5'd1; wb_wd = k;
      ll_valid = 1; ll_wa = 5'(20 + k); ll_wd = 32'hB0 + k;
      step();
    end
    set_idle();
    ra0 = 5'd3; ra1 = 5'd9; sb_rd = 5'd3;
    #2;
    check1("mid_pre_hz0", hz0, 1'b1);
    rst = 1'b1;
    #1;
    check1("mid_rst_empty", ll_empty, 1'b1);
    check1("mid_rst_rf_we", rf_we, 1'b0);
    check1("mid_rst_hz0", hz0, 1'b0);
    check1("mid_rst_hz1", hz1, 1'b0);
    check1("mid_rst_hz_rd", hz_rd, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check1("mid_post_empty", ll_empty, 1'b1);
    check1("mid_post_hz0", hz0, 1'b0);
    repeat (4) step();

    // bypass latency into an idle arbiter
    set_idle();
    ll_valid = 1; ll_wa = 5'd12; ll_wd = 32'hC0C0;
    step();
    check1("byp_lat1_we", rf_we, BYPASS);
    ll_valid = 0; ll_wa = 0; ll_wd = 0;
    step();
    check1("byp_lat2_we", rf_we, !BYPASS);
    step();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (!(ll_valid && !m_acc)) begin
        ll_valid = ($urandom_range(0, 2) != 0);
        ll_wa    = 5'($urandom_range(0, 31));
        ll_wd    = $urandom;
      end
      if (!m_hold) begin
        wb_we = ($urandom_range(0, 3) != 0);
        wb_wa = 5'($urandom_range(0, 31));
        wb_wd = $urandom;
      end
      sb_rd  = 5'($urandom_range(0, 31));
      sb_set = ($urandom_range(0, 1) == 1) && !m_pend[sb_rd];
      ra0 = 5'($urandom_range(0, 31));
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
